uart_tx_byte_queue: RTL and testbench
=====================================

// Module: uart_tx_byte_queue
// PURPOSE
//  Byte FIFO with a transmit sequencer that sits between the UART command/response logic and uart_tx.
//  Upstream pushes response bytes (0xAC write ack, read data high/low bytes, 0xEE ping reply).
//  A low-priority heartbeat byte is injected only when the queue is idle.
//  The sequencer drains the queue into uart_tx using the send/busy handshake.
//  Replaces the fixed 3-entry shift queue with a deeper buffer that can take back-to-back responses.
// PARAMETERS
//  DEPTH    16    FIFO entries; power of two, >= 2
//  AW       4     log2(DEPTH); pointer width
//  HB_BYTE  8'hAA heartbeat byte value
// PORTS
//  clk         in   1     single clock for the whole block (uart_clk domain)
//  rst         in   1     asynchronous, active-high reset
//  push        in   1     enqueue push_data this cycle
//  push_data   in   8     byte to enqueue
//  hb_tick     in   1     one-cycle heartbeat request pulse
//  hb_en       in   1     heartbeat enable (level)
//  full        out  1     FIFO holds DEPTH bytes (registered)
//  empty       out  1     FIFO holds 0 bytes (registered)
//  level       out  AW+1  current occupancy, 0..DEPTH
//  overflow    out  1     one-cycle pulse: push was dropped because full
//  uart_data   out  8     byte presented to uart_tx
//  uart_send   out  1     one-cycle send strobe to uart_tx
//  uart_busy   in   1     uart_tx busy; rises the cycle after uart_send
// BEHAVIOUR
//  Reset (async, rst=1): rd/wr pointers=0, level=0, empty=1, full=0, overflow=0,
//   uart_send=0, uart_data=8'h00, FSM=IDLE. Reset mid-transmission discards all queued bytes;
//   a byte already latched by uart_tx is not recalled.
//  Write side:
//   - push && !full: store push_data at wr_ptr; wr_ptr+1 wraps mod DEPTH.
//   - push && full: byte dropped; overflow=1 for one cycle. A pop in the same cycle does not rescue it.
//   - hb_tick accepted only if hb_en && empty && !push && FSM==IDLE; then HB_BYTE is enqueued.
//     Otherwise the heartbeat is silently dropped (no overflow). A push always wins over hb_tick.
//  Level accounting: level += write, -= pop; simultaneous write+pop leaves level unchanged.
//   full=(level==DEPTH), empty=(level==0); both are registered from the next level value.
//  Sequencer FSM (2 states):
//   IDLE : if !empty && !uart_busy -> uart_data<=mem[rd_ptr], uart_send<=1, rd_ptr+1 (wraps), go GUARD.
//   GUARD: uart_send<=0; stay one cycle so uart_busy can rise; -> IDLE.
//   uart_send is never high for two consecutive cycles.
//   While uart_busy=1 in IDLE, no pop occurs.
//  Latency: push sampled at edge k into an empty queue with uart_busy=0
//   -> uart_send high in the cycle after edge k+1.
//  Throughput: at most one byte per (2 cycles + uart_tx frame time). Order is strict FIFO.
//  Pop and push on the same entry (level==1 with pop and push together) is legal;
//   the read uses the old data.
// CONFIGURATION
//  UART_TXQ_STATS_EN defined: adds output drop_cnt [7:0].
//   - Counts dropped pushes (overflow pulses). Saturates at 8'hFF.
//   - Cleared by rst only. Heartbeat drops are not counted.
//  Not defined: port drop_cnt and its counter are absent. All other behaviour is identical.
// TESTING
//  1) Reset with rst=1 mid-run -> empty=1, level=0, uart_send=0, uart_data=00 while rst=1.
//  2) Push 0xEE into an empty queue with busy=0 -> one uart_send pulse with uart_data=EE
//     exactly 2 edges after push; level returns to 0.
//  3) Push 0x12,0x34 back-to-back; uart_tx model holds busy 20 cycles per byte
//     -> sends 12 then 34, second send only after busy falls, each strobe 1 cycle.
//  4) Hold busy=1 and push 17 bytes 00..10 (DEPTH=16) -> full=1 after 16,
//     overflow pulse on 17th, 0x10 never sent; release busy -> 00..0F in order.
//     With UART_TXQ_STATS_EN, drop_cnt=1.
//  5) hb_en=1, hb_tick on an empty queue -> AA sent. hb_tick in the same cycle as push 0xAC
//     -> only AC sent. hb_tick with level=3 -> dropped. hb_en=0 -> nothing sent.
//  6) Wrap-around: 40 pushes/pops with level oscillating 0..5 -> all 40 bytes out in order,
//     pointers wrap cleanly, no overflow.

Source files
------------

// File: rtl/uart_tx_byte_queue.sv
// Byte FIFO plus two-state send sequencer that feeds uart_tx over the send/busy handshake.
// Optional build macro UART_TXQ_STATS_EN adds a saturating drop_cnt output for dropped pushes.
module uart_tx_byte_queue #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [7:0] HB_BYTE = 8'hAA
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          hb_tick,
  input  logic          hb_en,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic [7:0]    uart_data,
  output logic          uart_send,
  input  logic          uart_busy
`ifdef UART_TXQ_STATS_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam logic [0:0]  ST_IDLE  = 1'b0;
  localparam logic [0:0]  ST_GUARD = 1'b1;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          full_r;
  logic          empty_r;
  logic          overflow_r;
  logic [7:0]    uart_data_r;
  logic          uart_send_r;
  logic [0:0]    state_r;

  logic          push_ok_s;
  logic          hb_ok_s;
  logic          drop_s;
  logic          wr_en_s;
  logic [7:0]    wr_byte_s;
  logic          pop_s;
  logic [AW:0]   level_nxt_s;

  // Write/pop decisions and next occupancy; a push always shadows a heartbeat request
  always_comb begin
    push_ok_s   = 1'b0;
    hb_ok_s     = 1'b0;
    drop_s      = 1'b0;
    wr_byte_s   = push_data;
    level_nxt_s = level_r;
    if (push) begin
      if (!full_r) begin
        push_ok_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      hb_ok_s = hb_tick && hb_en && empty_r && (state_r == ST_IDLE);
    end
    wr_en_s = push_ok_s || hb_ok_s;
    if (push_ok_s) begin
      wr_byte_s = push_data;
    end else begin
      wr_byte_s = HB_BYTE;
    end
    pop_s = (state_r == ST_IDLE) && !empty_r && !uart_busy;
    case ({wr_en_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage array; not reset, occupancy tracking makes stale contents unreachable
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wr_byte_s;
    end
  end

  // Write pointer, occupancy and the registered full/empty/overflow flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      level_r    <= {(AW+1){1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      level_r    <= level_nxt_s;
      full_r     <= (level_nxt_s == LVL_FULL);
      empty_r    <= (level_nxt_s == {(AW+1){1'b0}});
      overflow_r <= drop_s;
    end
  end

  // Sequencer: pop into uart_data with a one-cycle strobe, then a guard cycle for busy to rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      rd_ptr_r    <= {AW{1'b0}};
      uart_data_r <= 8'h00;
      uart_send_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            uart_data_r <= mem_r[rd_ptr_r];
            uart_send_r <= 1'b1;
            rd_ptr_r    <= rd_ptr_r + PTR_ONE;
            state_r     <= ST_GUARD;
          end else begin
            uart_send_r <= 1'b0;
          end
        end
        ST_GUARD: begin
          uart_send_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          uart_send_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TXQ_STATS_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of pushes lost to a full queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_r <= 8'h00;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'h01;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  assign full      = full_r;
  assign empty     = empty_r;
  assign level     = level_r;
  assign overflow  = overflow_r;
  assign uart_data = uart_data_r;
  assign uart_send = uart_send_r;

endmodule

// File: tb/tb_uart_tx_byte_queue.sv
// Directed bench for uart_tx_byte_queue: per-cycle vector table plus multi-cycle sequences.
module tb_uart_tx_byte_queue;

  logic       clk;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       hb_tick;
  logic       hb_en;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] uart_data;
  logic       uart_send;
  logic       uart_busy;
`ifdef UART_TXQ_STATS_EN
  logic [7:0] drop_cnt;
`endif

  uart_tx_byte_queue #(.DEPTH(16), .AW(4), .HB_BYTE(8'hAA)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .hb_tick   (hb_tick),
    .hb_en     (hb_en),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .uart_data (uart_data),
    .uart_send (uart_send),
    .uart_busy (uart_busy)
`ifdef UART_TXQ_STATS_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       p;
    logic [7:0] pd;
    logic       hb;
    logic       hbe;
    logic       b;
    logic       s;
    logic [7:0] d;
    logic [4:0] l;
  } vec_t;

  vec_t       vq[$];
  int         n_tests;
  int         n_fail;
  logic       busy_drv;
  logic       model_en;
  int         mcnt;
  int         cyc;
  logic [7:0] sent_q[$];
  int         sent_cyc[$];
  logic       prev_send;
  int         dbl_cnt;
  int         ovf_cnt;

  assign uart_busy = model_en ? (mcnt != 0) : busy_drv;

  // uart_tx stand-in: busy rises the cycle after a strobe and holds for 20 cycles
  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else if (uart_send) mcnt <= 20;
    else if (mcnt != 0) mcnt <= mcnt - 1;
  end

  // Record every strobe (byte and cycle), back-to-back strobes and overflow pulses
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (uart_send) begin
      sent_q.push_back(uart_data);
      sent_cyc.push_back(cyc);
    end
    if (uart_send && prev_send) dbl_cnt = dbl_cnt + 1;
    prev_send = uart_send;
    if (overflow) ovf_cnt = ovf_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic p, input logic [7:0] pd, input logic hb, input logic hbe,
                     input logic b, input logic s, input logic [7:0] d, input logic [4:0] l);
    vec_t v;
    v = '{p:p, pd:pd, hb:hb, hbe:hbe, b:b, s:s, d:d, l:l};
    vq.push_back(v);
  endtask

  task automatic wait_sends(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (sent_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(nm, 32'(sent_q.size()), 32'(n));
  endtask

  // {send, data, level, empty, full, overflow}
  function automatic logic [31:0] obs();
    return 32'({uart_send, uart_data, level, empty, full, overflow});
  endfunction

  function automatic logic [31:0] expv(input logic s, input logic [7:0] d, input logic [4:0] l,
                                       input logic f, input logic o);
    return 32'({s, d, l, (l == 5'd0), f, o});
  endfunction

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; prev_send = 1'b0; dbl_cnt = 0; ovf_cnt = 0;
    rst = 1'b1; push = 1'b0; push_data = 8'h00; hb_tick = 1'b0; hb_en = 1'b0;
    busy_drv = 1'b0; model_en = 1'b0;

    // Vector table: inputs for one edge, outputs expected right after it
    add(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 5'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, 5'd0); // heartbeat during guard cycle: dropped
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hEE, 5'd1); // idle + empty: accepted
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAA, 5'd0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 5'd0);
    add(1'b1, 8'hAC, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAA, 5'd1); // push beats heartbeat
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hAC, 5'd0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hAC, 5'd0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAC, 5'd0); // hb_en low
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAC, 5'd0);
    add(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAC, 5'd1);
    add(1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAC, 5'd2);
    add(1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAC, 5'd3);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAC, 5'd3); // heartbeat with level 3: dropped
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 5'd2);
    add(1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 5'd3);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 5'd2);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 5'd2);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 5'd1);
    add(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 5'd2);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 5'd1);
    add(1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 5'd1); // pop and push at level 1
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 5'd1);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h06, 5'd0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06, 5'd0);

    step(); step();
    check("reset_state", obs(), expv(1'b0, 8'h00, 5'd0, 1'b0, 1'b0));
    rst = 1'b0;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      push = vq[i].p; push_data = vq[i].pd; hb_tick = vq[i].hb; hb_en = vq[i].hbe;
      busy_drv = vq[i].b;
      step();
      check($sformatf("vec%0d", i), obs(), expv(vq[i].s, vq[i].d, vq[i].l, 1'b0, 1'b0));
    end
    push = 1'b0; hb_tick = 1'b0; hb_en = 1'b0; busy_drv = 1'b0;
    step();

    // Two back-to-back pushes against a 20-cycle busy uart_tx
    sent_q.delete(); sent_cyc.delete(); model_en = 1'b1;
    push = 1'b1; push_data = 8'h12; step();
    push_data = 8'h34; step();
    push = 1'b0;
    wait_sends(2, 100, "t3_count");
    if (sent_q.size() == 2) begin
      check("t3_byte0", 32'(sent_q[0]), 32'h12);
      check("t3_byte1", 32'(sent_q[1]), 32'h34);
      // strobe, guard, 20 busy cycles: second strobe 22 cycles after the first
      check("t3_gap", 32'(sent_cyc[1] - sent_cyc[0]), 32'd22);
    end
    for (int k = 0; k < 40 && mcnt != 0; k++) step();
    check("t3_busy_released", 32'(mcnt), 32'd0);
    model_en = 1'b0;
    step();

    // Fill to DEPTH with busy held; 17th push dropped even though a pop happens with it
    sent_q.delete(); ovf_cnt = 0; busy_drv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; push_data = 8'(i);
      step();
    end
    check("t4_full", 32'({full, empty, level}), 32'({1'b1, 1'b0, 5'd16}));
    push_data = 8'h10; busy_drv = 1'b0;
    step();
    check("t4_drop", obs(), expv(1'b1, 8'h00, 5'd15, 1'b0, 1'b1));
    push = 1'b0;
    step();
    check("t4_ovf_pulse", 32'(overflow), 32'd0);
    wait_sends(16, 100, "t4_count");
    step(); step();
    for (int i = 0; i < 16 && i < sent_q.size(); i++)
      check($sformatf("t4_byte%0d", i), 32'(sent_q[i]), 32'(i));
    check("t4_ovf_cnt", 32'(ovf_cnt), 32'd1);
    check("t4_level_end", 32'(level), 32'd0);
`ifdef UART_TXQ_STATS_EN
    check("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // Wrap-around: 8 bursts of 5 pushes, each drained before the next
    sent_q.delete(); ovf_cnt = 0;
    for (int b = 0; b < 8; b++) begin
      busy_drv = 1'b1;
      for (int j = 0; j < 5; j++) begin
        push = 1'b1; push_data = 8'(8'h40 + b * 5 + j);
        step();
      end
      push = 1'b0;
      check($sformatf("t6_level%0d", b), 32'(level), 32'd5);
      busy_drv = 1'b0;
      wait_sends((b + 1) * 5, 40, $sformatf("t6_count%0d", b));
    end
    step(); step();
    for (int i = 0; i < 40 && i < sent_q.size(); i++)
      check($sformatf("t6_byte%0d", i), 32'(sent_q[i]), 32'(8'h40 + i));
    check("t6_ovf_cnt", 32'(ovf_cnt), 32'd0);
    check("t6_level_end", 32'(level), 32'd0);

    // Reset mid-run with three bytes queued
    busy_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_data = 8'(8'hA1 + i);
      step();
    end
    push = 1'b0;
    sent_q.delete();
    #2 rst = 1'b1;
    #1 check("t1_rst_async", obs(), expv(1'b0, 8'h00, 5'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    check("t1_rst_held", obs(), expv(1'b0, 8'h00, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0; busy_drv = 1'b0;
    repeat (10) step();
    check("t1_no_send", 32'(sent_q.size()), 32'd0);
    check("t1_level", 32'({empty, level}), 32'({1'b1, 5'd0}));

    check("strobe_width", 32'(dbl_cnt), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
